fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_pkg.sv | 19 +
 rtl/fetch_controller_pc_unit.sv | 46 ++++
 rtl/fetch_controller.sv | 127 ++++++++++++
 tb/tb_fetch_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch path: FSM state encoding and
// word-alignment helpers used by both the controller and its PC unit.
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StHalt  = 2'd2,
        StFault = 2'd3
    } fetch_state_e;

    // Byte-address bits below the 32-bit word boundary.
    localparam int unsigned WordAlignBits = 2;

    function automatic logic is_word_aligned(input logic [WordAlignBits-1:0] low_bits);
        return low_bits == '0;
    endfunction

endpackage

// File: rtl/fetch_controller_pc_unit.sv
// Program counter register with +4 incrementer and a fetch-legality check
// (word alignment and program memory bounds) on the current PC.
module fetch_controller_pc_unit
    import fetch_controller_pkg::*;
#(
    parameter int unsigned           MEMORY_DEPTH = 64,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] target_i,
    input  logic                  advance_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  fetch_ok_o
);

    localparam logic [DATA_WIDTH-1:0] PcStep   = DATA_WIDTH'(1 << WordAlignBits);
    localparam logic [DATA_WIDTH-1:0] WordsMax = DATA_WIDTH'(MEMORY_DEPTH);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (advance_i) begin
            pc_d = pc_q + PcStep;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Checked before any use of the incremented value, so a wrap never fetches.
    assign fetch_ok_o = is_word_aligned(pc_q[WordAlignBits-1:0])
                        && ((pc_q >> WordAlignBits) < WordsMax);
    assign pc_o       = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: IDLE/RUN/HALT/FAULT FSM and a single-entry
// instruction register with a valid/ready handshake toward decode.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int unsigned           MEMORY_DEPTH = 64,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    input  logic                  redirect_valid_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    input  logic                  halt_req_i,
    output logic [DATA_WIDTH-1:0] pm_address_o,
    input  logic [DATA_WIDTH-1:0] pm_instruction_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic                  fault_o,
    output logic [1:0]            state_o
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] pc;
    logic                  fetch_ok;
    logic                  pc_load;
    logic                  pc_advance;

    fetch_controller_pc_unit #(
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .RESET_PC     (RESET_PC)
    ) u_pc_unit (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .load_i     (pc_load),
        .target_i   (redirect_target_i),
        .advance_i  (pc_advance),
        .pc_o       (pc),
        .fetch_ok_o (fetch_ok)
    );

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        pc_load    = 1'b0;
        pc_advance = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d = StRun;
                end
            end
            StRun, StHalt: begin
                if (redirect_valid_i) begin
                    // Redirect flushes the held word and beats halt or a fetch.
                    valid_d = 1'b0;
                    if (is_word_aligned(redirect_target_i[WordAlignBits-1:0])) begin
                        pc_load = 1'b1;
                        state_d = StRun;
                    end else begin
                        state_d = StFault;
                        fault_d = 1'b1;
                    end
                end else begin
                    if (valid_q && instr_ready_i) begin
                        valid_d = 1'b0;
                    end
                    if (state_q == StRun) begin
                        if (halt_req_i) begin
                            state_d = StHalt;
                        end else if (!valid_q || instr_ready_i) begin
                            if (fetch_ok) begin
                                instr_d    = pm_instruction_i;
                                instr_pc_d = pc;
                                valid_d    = 1'b1;
                                pc_advance = 1'b1;
                            end else begin
                                state_d = StFault;
                                fault_d = 1'b1;
                                valid_d = 1'b0;
                            end
                        end
                    end
                end
            end
            StFault: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    assign pm_address_o  = pc;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign fault_o       = fault_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a ROM whose word i holds i, directed
// handshake/redirect/halt/reset sequences, and a small-memory instance for faults.
module tb_fetch_controller;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic        en_a = 0, rv_a = 0, halt_a = 0, rdy_a = 0;
    logic [31:0] rt_a = '0, pma_a, pmi_a, ins_a, ipc_a;
    logic        vld_a, flt_a;
    logic [1:0]  st_a;

    logic        en_b = 0, rv_b = 0, halt_b = 0, rdy_b = 0;
    logic [31:0] rt_b = '0, pma_b, pmi_b, ins_b, ipc_b;
    logic        vld_b, flt_b;
    logic [1:0]  st_b;

    // Program memories live beside the controllers: word i holds value i.
    assign pmi_a = pma_a >> 2;
    assign pmi_b = pma_b >> 2;

    fetch_controller dut_a (
        .clk_i             (clk),
        .reset_ni          (reset_n),
        .enable_i          (en_a),
        .redirect_valid_i  (rv_a),
        .redirect_target_i (rt_a),
        .halt_req_i        (halt_a),
        .pm_address_o      (pma_a),
        .pm_instruction_i  (pmi_a),
        .instr_valid_o     (vld_a),
        .instr_ready_i     (rdy_a),
        .instr_o           (ins_a),
        .instr_pc_o        (ipc_a),
        .fault_o           (flt_a),
        .state_o           (st_a)
    );

    fetch_controller #(.MEMORY_DEPTH(4)) dut_b (
        .clk_i             (clk),
        .reset_ni          (reset_n),
        .enable_i          (en_b),
        .redirect_valid_i  (rv_b),
        .redirect_target_i (rt_b),
        .halt_req_i        (halt_b),
        .pm_address_o      (pma_b),
        .pm_instruction_i  (pmi_b),
        .instr_valid_o     (vld_b),
        .instr_ready_i     (rdy_b),
        .instr_o           (ins_b),
        .instr_pc_o        (ipc_b),
        .fault_o           (flt_b),
        .state_o           (st_b)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        sb.push_back('{pc: pc, ins: ins});
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_state"}, 32'(st_a), 32'd0);
        chk({tag, "_pm_address"}, pma_a, 32'h0);
        chk({tag, "_valid"}, 32'(vld_a), 32'd0);
        chk({tag, "_fault"}, 32'(flt_a), 32'd0);
        chk({tag, "_instr"}, ins_a, 32'h0);
        chk({tag, "_instr_pc"}, ipc_a, 32'h0);
    endtask

    // Monitor: every accepted word must be the next expected one.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && vld_a && rdy_a) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_word: got pc %h instr %h, required none", ipc_a, ins_a);
            end else begin
                e = sb.pop_front();
                if (ipc_a === e.pc && ins_a === e.ins) passes++;
                else $display("FAIL accepted_word: got pc %h instr %h, required pc %h instr %h",
                              ipc_a, ins_a, e.pc, e.ins);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        #2 reset_n = 1'b0;
        #2;
        chk_reset_a("por");
        chk("por_b_state", 32'(st_b), 32'd0);
        step();
        step();
        reset_n = 1'b1;

        // Sequential stream, then a 3-cycle stall at 0x8.
        en_a = 1; rdy_a = 1;
        push(32'h0, 0); push(32'h4, 1); push(32'h8, 2); push(32'hc, 3);
        step();
        chk("enter_run", 32'(st_a), 32'd1);
        step();
        step();
        step();
        rdy_a = 0; en_a = 0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_pc", ipc_a, 32'h8);
            chk("stall_instr", ins_a, 32'd2);
            chk("stall_pm_address", pma_a, 32'hc);
            step();
        end
        chk("stall_valid_held", 32'(vld_a), 32'd1);
        rdy_a = 1;
        step();
        step();

        // Redirect flushes an un-accepted word at 0x10.
        rdy_a = 0;
        chk("pre_redirect_pc", ipc_a, 32'h10);
        rv_a = 1; rt_a = 32'h20;
        push(32'h20, 8);
        step();
        rv_a = 0;
        chk("redirect_flush_valid", 32'(vld_a), 32'd0);
        chk("redirect_pm_address", pma_a, 32'h20);
        rdy_a = 1;
        step();

        // Halt and redirect together: redirect wins.
        halt_a = 1; rv_a = 1; rt_a = 32'h10;
        push(32'h10, 4);
        step();
        halt_a = 0; rv_a = 0;
        chk("halt_redirect_state", 32'(st_a), 32'd1);
        chk("halt_redirect_pm", pma_a, 32'h10);
        step();

        // Halt alone freezes the PC; enable has no effect.
        halt_a = 1;
        step();
        halt_a = 0;
        chk("halt_state", 32'(st_a), 32'd2);
        chk("halt_valid", 32'(vld_a), 32'd0);
        chk("halt_pm", pma_a, 32'h14);
        en_a = 1;
        step();
        en_a = 0;
        chk("halt_hold_state", 32'(st_a), 32'd2);
        chk("halt_hold_pm", pma_a, 32'h14);

        // Leave HALT by redirect, then reset with a word pending and PC=0x14.
        rdy_a = 0; rv_a = 1; rt_a = 32'h10;
        step();
        rv_a = 0;
        chk("halt_exit_state", 32'(st_a), 32'd1);
        step();
        chk("pending_valid", 32'(vld_a), 32'd1);
        chk("pending_pc", ipc_a, 32'h10);
        chk("pending_pm", pma_a, 32'h14);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_a("async_reset");
        step();
        reset_n = 1'b1;
        chk("queue_drained_1", 32'(sb.size()), 32'd0);

        // Restart from RESET_PC; redirect drops the un-accepted 0x8.
        en_a = 1; rdy_a = 1;
        push(32'h0, 0); push(32'h4, 1); push(32'h20, 8);
        step();
        step();
        step();
        step();
        rdy_a = 0;
        chk("restart_pc8", ipc_a, 32'h8);
        rv_a = 1; rt_a = 32'h20;
        step();
        rv_a = 0; rdy_a = 1;
        chk("drop_pc8_valid", 32'(vld_a), 32'd0);
        step();
        halt_a = 1;
        step();
        halt_a = 0;
        chk("final_halt_state", 32'(st_a), 32'd2);
        chk("queue_drained_2", 32'(sb.size()), 32'd0);

        // Small memory: running off the end faults.
        en_b = 1; rdy_b = 1;
        for (int i = 0; i < 5; i++) step();
        chk("b_last_pc", ipc_b, 32'hc);
        chk("b_last_valid", 32'(vld_b), 32'd1);
        step();
        chk("b_range_fault", 32'(flt_b), 32'd1);
        chk("b_range_state", 32'(st_b), 32'd3);
        chk("b_range_valid", 32'(vld_b), 32'd0);
        rv_b = 1; rt_b = 32'h0;
        step();
        rv_b = 0;
        chk("b_fault_sticky", 32'(st_b), 32'd3);

        // Misaligned redirect faults.
        #2 reset_n = 1'b0;
        #1;
        chk("b_reset_fault", 32'(flt_b), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("b_run_again", 32'(st_b), 32'd1);
        rv_b = 1; rt_b = 32'h1;
        step();
        rv_b = 0;
        chk("b_misalign_fault", 32'(flt_b), 32'd1);
        chk("b_misalign_state", 32'(st_b), 32'd3);
        chk("b_misalign_valid", 32'(vld_b), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
